// File: rtl/vram_fill_engine.sv
// vram_fill_engine: rectangle fill writer for the 20x15 byte-per-cell video
// region. Each fill command becomes word read-modify-write accesses on a shared
// request/grant memory port. The traversal is row-major with ascending addresses.
// Optional build macro VRAM_FILL_FULLWORD_EN: a word whose four lanes all lie
// inside the rectangle skips the read and is written as {4{colour}} directly.
//
// state | meaning
// IDLE  | waiting for cmd_start, command fields are latched on start
// CLIP  | clip the rectangle to the region, reject empty commands
// RD    | read the current word (mem_req=1, mem_we=0) until granted
// WR    | write the merged word (mem_req=1, mem_we=1) until granted
// DONE  | one-cycle done pulse, then back to IDLE
module vram_fill_engine #(
  parameter int VBASE  = 65,
  parameter int COLS   = 20,
  parameter int ROWS   = 15,
  parameter int ADDR_W = 9
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [4:0]        cmd_x,
  input  logic [3:0]        cmd_y,
  input  logic [4:0]        cmd_w,
  input  logic [3:0]        cmd_h,
  input  logic [7:0]        cmd_color,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, CLIP, RD, WR, DONE} state_t;

  state_t      state;
  logic [4:0]  x_q, w_q;
  logic [3:0]  y_q, h_q;
  logic [7:0]  color_q;
  logic [3:0]  row_q;
  logic [2:0]  word_q;

  logic [5:0]  x_sum, y_sum, xe, ye;
  logic        empty, more_words, more_rows, issue, skip_rd;
  logic [3:0]  nxt_row;
  logic [2:0]  nxt_word;
  logic [ADDR_W-1:0] nxt_addr;

  // Bit b of the mask covers byte [8b+7:8b]; lane 0 (lowest column) is byte 3.
  function automatic logic [3:0] lane_mask(input logic [2:0] wd, input logic [4:0] xs,
                                           input logic [5:0] xend);
    logic [3:0] m;
    logic [5:0] c;
    m = '0;
    for (int l = 0; l < 4; l++) begin
      c = {1'b0, wd, 2'(l)};
      m[3-l] = (c >= {1'b0, xs}) && (c < xend);
    end
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                        input logic [7:0] col);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = col;
    end
    return r;
  endfunction

  // Clip bounds and next-word selection, shared by CLIP and WR.
  always_comb begin
    x_sum      = {1'b0, x_q} + {1'b0, w_q};
    y_sum      = {2'b00, y_q} + {2'b00, h_q};
    xe         = (x_sum > 6'(COLS)) ? 6'(COLS) : x_sum;
    ye         = (y_sum > 6'(ROWS)) ? 6'(ROWS) : y_sum;
    empty      = (w_q == 5'd0) || (h_q == 4'd0) ||
                 ({1'b0, x_q} >= 6'(COLS)) || ({2'b00, y_q} >= 6'(ROWS));
    more_words = ({1'b0, word_q, 2'b00} + 6'd4) < xe;
    more_rows  = ({2'b00, row_q} + 6'd1) < ye;
    nxt_row    = y_q;
    nxt_word   = x_q[4:2];
    if (state == WR) begin
      if (more_words) begin
        nxt_row  = row_q;
        nxt_word = word_q + 3'd1;
      end else begin
        nxt_row  = row_q + 4'd1;
      end
    end
    nxt_addr = ADDR_W'(VBASE) + ADDR_W'(nxt_row) * ADDR_W'(5) + ADDR_W'(nxt_word);
    issue    = ((state == CLIP) && !empty) ||
               ((state == WR) && mem_gnt && (more_words || more_rows));
`ifdef VRAM_FILL_FULLWORD_EN
    skip_rd  = &lane_mask(nxt_word, x_q, xe);
`else
    skip_rd  = 1'b0;
`endif
  end

  // Fill sequencer with registered port outputs.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      row_q     <= '0;
      word_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
            busy    <= 1'b1;
            state   <= CLIP;
          end
        end
        CLIP: begin
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        RD: begin
          if (mem_gnt) begin
            mem_wdata <= merge(mem_rdata, lane_mask(word_q, x_q, xe), color_q);
            mem_we    <= 1'b1;
            state     <= WR;
          end
        end
        WR: begin
          if (mem_gnt && !(more_words || more_rows)) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (issue) begin
        row_q    <= nxt_row;
        word_q   <= nxt_word;
        mem_req  <= 1'b1;
        mem_addr <= nxt_addr;
        if (skip_rd) begin
          mem_we    <= 1'b1;
          mem_wdata <= {4{color_q}};
          state     <= WR;
        end else begin
          mem_we <= 1'b0;
          state  <= RD;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_fill_engine.sv
// tb_vram_fill_engine: directed checks of the rectangle fill writer against a
// word-addressed memory model with a controllable grant.
module tb_vram_fill_engine;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [4:0]  cmd_x = '0;
  logic [3:0]  cmd_y = '0;
  logic [4:0]  cmd_w = '0;
  logic [3:0]  cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        busy, done, mem_req, mem_gnt, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] ram [0:511];
  logic        gnt_en = 1'b1;
  logic        blk_wr = 1'b0;
  logic        poke_en = 1'b0;
  logic [8:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;
  logic        clr = 1'b0;
  int          rd_cnt, wr_cnt, max_a, min_a;
  logic        req_seen;

  int total = 0;
  int bad = 0;

  vram_fill_engine dut (
    .sysclk(sysclk), .reset(reset), .cmd_start(cmd_start),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 sysclk = ~sysclk;

  assign mem_gnt   = gnt_en && !(blk_wr && mem_we);
  assign mem_rdata = ram[mem_addr];

  // Memory model and access statistics.
  always @(posedge sysclk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    if (clr) begin
      rd_cnt   <= 0;
      wr_cnt   <= 0;
      max_a    <= 0;
      min_a    <= 511;
      req_seen <= 1'b0;
    end else begin
      if (mem_req) req_seen <= 1'b1;
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          ram[mem_addr] <= mem_wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
        if (int'(mem_addr) > max_a) max_a <= int'(mem_addr);
        if (int'(mem_addr) < min_a) min_a <= int'(mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge sysclk);
    poke_en   = 1'b1;
    poke_addr = 9'(a);
    poke_data = d;
    @(negedge sysclk);
    poke_en = 1'b0;
  endtask

  task automatic clear_stats();
    @(negedge sysclk);
    clr = 1'b1;
    @(negedge sysclk);
    clr = 1'b0;
  endtask

  // Issues one command at a negedge; lat counts negedges until done is seen.
  task automatic run_cmd(input logic [4:0] x, input logic [3:0] y, input logic [4:0] w,
                         input logic [3:0] h, input logic [7:0] c,
                         output int lat, output int bcnt);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_start = 1'b1;
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge sysclk);
      cmd_start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, bcnt, k;
    logic stable;
    logic [8:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_req, s_we;

    // Reset state
    reset = 1'b1;
    clr   = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    clr   = 1'b0;

    // Single cell
    poke(65, 32'h11223344);
    clear_stats();
    @(negedge sysclk);
    run_cmd(5'd0, 4'd0, 5'd1, 4'd1, 8'h3F, lat, bcnt);
    @(negedge sysclk);
    chk("single_ram", ram[65], 32'h3F223344);
    chk("single_rd", 32'(rd_cnt), 32'd1);
    chk("single_wr", 32'(wr_cnt), 32'd1);
    chk("single_lat", 32'(lat), 32'd4);

    // Clipping at the bottom-right corner
    poke(139, 32'h0);
    clear_stats();
    run_cmd(5'd18, 4'd14, 5'd5, 4'd3, 8'h15, lat, bcnt);
    @(negedge sysclk);
    chk("clip_ram", ram[139], 32'h00001515);
    chk("clip_rd", 32'(rd_cnt), 32'd1);
    chk("clip_wr", 32'(wr_cnt), 32'd1);
    chk("clip_max", 32'(max_a), 32'd139);
    chk("clip_min", 32'(min_a), 32'd139);

    // Full row
    for (int a = 75; a <= 79; a++) poke(a, 32'hDEADBEEF);
    poke(74, 32'h01020304);
    poke(80, 32'h05060708);
    clear_stats();
    run_cmd(5'd0, 4'd2, 5'd20, 4'd1, 8'h2A, lat, bcnt);
    @(negedge sysclk);
    for (int a = 75; a <= 79; a++) chk($sformatf("row_ram%0d", a), ram[a], 32'h2A2A2A2A);
    chk("row_prev", ram[74], 32'h01020304);
    chk("row_next", ram[80], 32'h05060708);
    chk("row_wr", 32'(wr_cnt), 32'd5);
`ifdef VRAM_FILL_FULLWORD_EN
    chk("row_rd", 32'(rd_cnt), 32'd0);
`else
    chk("row_rd", 32'(rd_cnt), 32'd5);
`endif

    // Empty commands: zero width, then row beyond the region
    clear_stats();
    run_cmd(5'd3, 4'd3, 5'd0, 4'd2, 8'hFF, lat, bcnt);
    chk("w0_lat", 32'(lat), 32'd2);
    chk("w0_busy", 32'(bcnt), 32'd2);
    @(negedge sysclk);
    chk("w0_idle", 32'(busy), 32'd0);
    chk("w0_req", 32'(req_seen), 32'd0);
    clear_stats();
    run_cmd(5'd0, 4'd15, 5'd4, 4'd1, 8'hFF, lat, bcnt);
    chk("y15_lat", 32'(lat), 32'd2);
    chk("y15_busy", 32'(bcnt), 32'd2);
    @(negedge sysclk);
    chk("y15_req", 32'(req_seen), 32'd0);

    // Grant stall in RD with an ignored second start
    poke(90, 32'hA5A5A5A5);
    poke(91, 32'hA5A5A5A5);
    poke(95, 32'hA5A5A5A5);
    poke(96, 32'hA5A5A5A5);
    poke(65, 32'h0BADF00D);
    clear_stats();
    gnt_en = 1'b0;
    cmd_x = 5'd1; cmd_y = 4'd5; cmd_w = 5'd6; cmd_h = 4'd2; cmd_color = 8'hC3;
    cmd_start = 1'b1;
    @(negedge sysclk);
    cmd_start = 1'b0;
    @(negedge sysclk);
    s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    chk("stall_addr", 32'(s_addr), 32'd90);
    chk("stall_req", {30'd0, s_req, s_we}, 32'd2);
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        cmd_x = 5'd0; cmd_y = 4'd0; cmd_w = 5'd1; cmd_h = 4'd1; cmd_color = 8'hFF;
        cmd_start = 1'b1;
      end
      @(negedge sysclk);
      cmd_start = 1'b0;
      if (mem_req !== s_req || mem_we !== s_we || mem_addr !== s_addr ||
          mem_wdata !== s_wdata || busy !== 1'b1)
        stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    gnt_en = 1'b1;
    k = 0;
    while (!done && k < 200) begin
      @(negedge sysclk);
      k++;
    end
    chk("stall_done", 32'(done), 32'd1);
    repeat (3) @(negedge sysclk);
    chk("stall_idle", 32'(busy), 32'd0);
    chk("stall_r5w0", ram[90], 32'hA5C3C3C3);
    chk("stall_r5w1", ram[91], 32'hC3C3C3A5);
    chk("stall_r6w0", ram[95], 32'hA5C3C3C3);
    chk("stall_r6w1", ram[96], 32'hC3C3C3A5);
    chk("stall_wr", 32'(wr_cnt), 32'd4);
    chk("stall_ign", ram[65], 32'h0BADF00D);

    // Reset while waiting for a write grant
    poke(65, 32'h12345678);
    clear_stats();
    blk_wr = 1'b1;
    cmd_x = 5'd0; cmd_y = 4'd0; cmd_w = 5'd4; cmd_h = 4'd1; cmd_color = 8'h77;
    cmd_start = 1'b1;
    k = 0;
    do begin
      @(negedge sysclk);
      cmd_start = 1'b0;
      k++;
    end while (!(mem_req && mem_we) && k < 50);
    chk("rmid_in_wr", 32'(mem_req && mem_we), 32'd1);
    reset = 1'b1;
    @(negedge sysclk);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_req", 32'(mem_req), 32'd0);
    reset  = 1'b0;
    blk_wr = 1'b0;
    chk("rmid_ram", ram[65], 32'h12345678);
    run_cmd(5'd0, 4'd0, 5'd2, 4'd1, 8'h77, lat, bcnt);
    @(negedge sysclk);
    chk("rmid_new_lat", 32'(lat), 32'd4);
    chk("rmid_new_ram", ram[65], 32'h77775678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
